// File: rtl/chime_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : chime_ctrl
//  Purpose  : Request-side controller for the music player. Arbitrates alarm,
//             hourly chime and key-click requests into a one-hot `start` level,
//             times tune and gap durations, repeats the alarm, and keeps the
//             user volume setting.
//  Options  : CHIME_KEYCLICK_EN - when defined, key_hit is live and the click
//             tune uses start[2]; otherwise key_hit is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module chime_ctrl #(
    parameter int MSC_N     = 5,
    parameter int TICK_DIV  = 50000,
    parameter int ALARM_MS  = 500,
    parameter int CHIME_MS  = 200,
    parameter int CLICK_MS  = 30,
    parameter int GAP_MS    = 100,
    parameter int ALARM_REP = 10,
    parameter int VOL_STEP  = 32,
    parameter int VOL_INIT  = 32
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             alarm_hit,
    input  logic             hour_hit,
    input  logic             key_hit,
    input  logic             stop_key,
    input  logic             vol_up,
    input  logic             vol_dn,
    output logic [MSC_N-1:0] start,
    output logic [9:0]       volume,
    output logic             busy
);

    localparam int MAX_AC  = (ALARM_MS > CHIME_MS) ? ALARM_MS : CHIME_MS;
    localparam int MAX_KG  = (CLICK_MS > GAP_MS) ? CLICK_MS : GAP_MS;
    localparam int TMR_MAX = (MAX_AC > MAX_KG) ? MAX_AC : MAX_KG;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // Repeat counter only ever holds values up to ALARM_REP-1.
    localparam int REP_W   = (ALARM_REP > 1) ? $clog2(ALARM_REP) : 1;
    localparam int VOL_MAX = 1023 - (1023 % VOL_STEP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_ALARM = 2'd0,
        SRC_CHIME = 2'd1,
        SRC_CLICK = 2'd2
    } src_t;

    state_t             state_q, state_d;
    src_t               src_q, src_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [MSC_N-1:0]   start_q, start_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic               alarm_flag_q, alarm_flag_d;
    logic               chime_flag_q, chime_flag_d;
    logic [9:0]         vol_q, vol_d;
    logic               click_flag;
    logic               click_take;

    logic               w_tick;
    logic               w_expire;
    logic               w_alarm_active;
    logic               w_stop_abort;
    logic               w_preempt;

    assign w_tick         = (pre_q == PRE_W'(TICK_DIV - 1));
    // Expire on the tick that would take the timer to zero, so a tune of
    // N ticks lasts exactly N*TICK_DIV cycles.
    assign w_expire       = w_tick && (tmr_q <= TMR_W'(1));
    assign w_alarm_active = (state_q != S_IDLE) && (src_q == SRC_ALARM);
    assign w_stop_abort   = (src_q == SRC_ALARM) && stop_key;
    assign w_preempt      = (src_q != SRC_ALARM) && alarm_flag_q && !stop_key;

`ifdef CHIME_KEYCLICK_EN
    logic click_flag_q, click_flag_d;

    // Click request flag: set by key_hit, cleared when the FSM takes it.
    always_comb begin
        click_flag_d = click_flag_q;
        if (key_hit)    click_flag_d = 1'b1;
        if (click_take) click_flag_d = 1'b0;
    end

    // Click flag register.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) click_flag_q <= 1'b0;
        else     click_flag_q <= click_flag_d;
    end

    assign click_flag = click_flag_q;
`else
    logic unused_click;
    assign unused_click = key_hit | click_take;
    assign click_flag   = 1'b0;
`endif

    // Next-state logic: flags, arbitration, tune/gap timing, alarm repeats.
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        tmr_d        = tmr_q;
        pre_d        = w_tick ? '0 : pre_q + PRE_W'(1);
        start_d      = start_q;
        rep_d        = rep_q;
        alarm_flag_d = alarm_flag_q;
        chime_flag_d = chime_flag_q;
        click_take   = 1'b0;

        // While the alarm runs, a new alarm_hit reloads the repeats instead.
        if (alarm_hit && !w_alarm_active) alarm_flag_d = 1'b1;
        if (hour_hit)                     chime_flag_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (alarm_flag_q && !stop_key) begin
                    alarm_flag_d = 1'b0;
                    rep_d        = REP_W'(ALARM_REP - 1);
                    src_d        = SRC_ALARM;
                    start_d      = MSC_N'(1);
                    tmr_d        = TMR_W'(ALARM_MS);
                    pre_d        = '0;
                    state_d      = S_PLAY;
                end else if (chime_flag_q) begin
                    chime_flag_d = 1'b0;
                    src_d        = SRC_CHIME;
                    start_d      = MSC_N'(2);
                    tmr_d        = TMR_W'(CHIME_MS);
                    pre_d        = '0;
                    state_d      = S_PLAY;
                end else if (click_flag) begin
                    click_take   = 1'b1;
                    src_d        = SRC_CLICK;
                    start_d      = MSC_N'(4);
                    tmr_d        = TMR_W'(CLICK_MS);
                    pre_d        = '0;
                    state_d      = S_PLAY;
                end
            end
            S_PLAY: begin
                if (w_expire || w_stop_abort || w_preempt) begin
                    start_d = '0;
                    tmr_d   = TMR_W'(GAP_MS);
                    pre_d   = '0;
                    state_d = S_GAP;
                end else if (w_tick) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_GAP: begin
                if (w_expire) begin
                    if ((src_q == SRC_ALARM) && (rep_q != '0) && !stop_key) begin
                        rep_d   = rep_q - REP_W'(1);
                        start_d = MSC_N'(1);
                        tmr_d   = TMR_W'(ALARM_MS);
                        pre_d   = '0;
                        state_d = S_PLAY;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (w_tick) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: begin
                start_d = '0;
                state_d = S_IDLE;
            end
        endcase

        if (alarm_hit && w_alarm_active) rep_d = REP_W'(ALARM_REP - 1);

        // Stop always wins over any alarm request or reload in the same cycle.
        if (stop_key) begin
            alarm_flag_d = 1'b0;
            rep_d        = '0;
        end
    end

    // Saturating volume update; simultaneous up/down leaves it unchanged.
    always_comb begin
        logic [10:0] vol_sum;
        vol_sum = {1'b0, vol_q} + 11'(VOL_STEP);
        vol_d   = vol_q;
        if (vol_up && !vol_dn) begin
            vol_d = (vol_sum > 11'(VOL_MAX)) ? 10'(VOL_MAX) : vol_sum[9:0];
        end else if (vol_dn && !vol_up) begin
            vol_d = (vol_q < 10'(VOL_STEP)) ? '0 : vol_q - 10'(VOL_STEP);
        end
    end

    // State and datapath registers.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            src_q        <= SRC_ALARM;
            tmr_q        <= '0;
            pre_q        <= '0;
            start_q      <= '0;
            rep_q        <= '0;
            alarm_flag_q <= 1'b0;
            chime_flag_q <= 1'b0;
            vol_q        <= 10'(VOL_INIT);
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            tmr_q        <= tmr_d;
            pre_q        <= pre_d;
            start_q      <= start_d;
            rep_q        <= rep_d;
            alarm_flag_q <= alarm_flag_d;
            chime_flag_q <= chime_flag_d;
            vol_q        <= vol_d;
        end
    end

    assign start  = start_q;
    assign volume = vol_q;
    assign busy   = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_chime_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_chime_ctrl
//  Purpose  : Self-checking bench for chime_ctrl. Expected `start` waveforms
//             are built as run-length lists from tune/gap durations; volume
//             is tracked with a saturating arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_chime_ctrl;

    localparam int T     = 10;
    localparam int A_MS  = 5;
    localparam int C_MS  = 4;
    localparam int K_MS  = 2;
    localparam int G_MS  = 3;
    localparam int REP   = 3;
    localparam int STEP  = 32;
    localparam int VMAX  = 992;
    localparam int A_LEN = A_MS * T;
    localparam int C_LEN = C_MS * T;
    localparam int K_LEN = K_MS * T;
    localparam int G_LEN = G_MS * T;

`ifdef CHIME_KEYCLICK_EN
    localparam bit CLICK_EN = 1'b1;
`else
    localparam bit CLICK_EN = 1'b0;
`endif

    logic       sysclk    = 1'b0;
    logic       rst       = 1'b1;
    logic       alarm_hit = 1'b0;
    logic       hour_hit  = 1'b0;
    logic       key_hit   = 1'b0;
    logic       stop_key  = 1'b0;
    logic       vol_up    = 1'b0;
    logic       vol_dn    = 1'b0;
    logic [4:0] start;
    logic [9:0] volume;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int mv     = 32;

    typedef struct {
        logic [4:0] val;
        int         len;
    } run_t;

    run_t       exp_q[$];
    logic [4:0] obs_start[$];
    logic       obs_busy[$];

    chime_ctrl #(
        .MSC_N     (5),
        .TICK_DIV  (T),
        .ALARM_MS  (A_MS),
        .CHIME_MS  (C_MS),
        .CLICK_MS  (K_MS),
        .GAP_MS    (G_MS),
        .ALARM_REP (REP),
        .VOL_STEP  (STEP),
        .VOL_INIT  (32)
    ) dut (
        .sysclk    (sysclk),
        .rst       (rst),
        .alarm_hit (alarm_hit),
        .hour_hit  (hour_hit),
        .key_hit   (key_hit),
        .stop_key  (stop_key),
        .vol_up    (vol_up),
        .vol_dn    (vol_dn),
        .start     (start),
        .volume    (volume),
        .busy      (busy)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    // Append a run to the expected waveform, merging equal neighbours.
    task automatic add_run(input logic [4:0] v, input int l);
        run_t r;
        int   last;
        if (l <= 0) return;
        last = exp_q.size() - 1;
        if (last >= 0 && exp_q[last].val == v) begin
            r = exp_q[last];
            r.len += l;
            exp_q[last] = r;
        end else begin
            r.val = v;
            r.len = l;
            exp_q.push_back(r);
        end
    endtask

    task automatic add_alarm_bursts(input int n);
        for (int k = 0; k < n; k++) begin
            add_run(5'b00001, A_LEN);
            add_run(5'b00000, G_LEN);
        end
    endtask

    // Record n samples; optionally raise stop_key / alarm_hit for one sample.
    task automatic capture(input int n, input int stop_idx, input int alarm_idx);
        obs_start.delete();
        obs_busy.delete();
        for (int i = 0; i < n; i++) begin
            stop_key  = (i == stop_idx);
            alarm_hit = (i == alarm_idx);
            step();
            obs_start.push_back(start);
            obs_busy.push_back(busy);
        end
        stop_key  = 1'b0;
        alarm_hit = 1'b0;
    endtask

    task automatic check_runs(input string tag);
        run_t o[$];
        run_t r;
        int   last;
        foreach (obs_start[i]) begin
            last = o.size() - 1;
            if (last >= 0 && o[last].val === obs_start[i]) begin
                r = o[last];
                r.len++;
                o[last] = r;
            end else begin
                r.val = obs_start[i];
                r.len = 1;
                o.push_back(r);
            end
        end
        chk({tag, " run_count"}, o.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < o.size(); i++) begin
            chk($sformatf("%s run%0d_val", tag, i), 32'(o[i].val), 32'(exp_q[i].val));
            chk($sformatf("%s run%0d_len", tag, i), o[i].len, exp_q[i].len);
        end
        exp_q.delete();
    endtask

    task automatic vol_op(input logic up, input logic dn, input string tag);
        vol_up = up;
        vol_dn = dn;
        step();
        vol_up = 1'b0;
        vol_dn = 1'b0;
        if (up && !dn)      mv = (mv + STEP > VMAX) ? VMAX : mv + STEP;
        else if (dn && !up) mv = (mv < STEP) ? 0 : mv - STEP;
        chk(tag, 32'(volume), mv);
    endtask

    task automatic idle_gap();
        repeat ($urandom_range(1, 6)) step();
    endtask

    initial begin
        int a;
        int s;
        int n;
        int any_busy;

        // Reset state, held through release.
        repeat (3) step();
        chk("rst start", 32'(start), 0);
        chk("rst volume", 32'(volume), 32);
        chk("rst busy", 32'(busy), 0);
        rst = 1'b0;
        step();
        chk("rel start", 32'(start), 0);
        chk("rel volume", 32'(volume), 32);
        chk("rel busy", 32'(busy), 0);
        idle_gap();

        // Key click.
        key_hit = 1'b1;
        step();
        key_hit = 1'b0;
        n = K_LEN + G_LEN + 5;
        capture(n, -1, -1);
        if (CLICK_EN) begin
            add_run(5'b00100, K_LEN);
            add_run(5'b00000, n - K_LEN);
        end else begin
            add_run(5'b00000, n);
        end
        check_runs("click");
        chk("click busy_end", 32'(obs_busy[K_LEN + G_LEN - 1]), 32'(CLICK_EN));
        chk("click busy_idle", 32'(obs_busy[K_LEN + G_LEN]), 0);
        idle_gap();

        // Full alarm: REP bursts separated by gaps.
        alarm_hit = 1'b1;
        step();
        alarm_hit = 1'b0;
        n = REP * (A_LEN + G_LEN) + 10;
        capture(n, -1, -1);
        add_alarm_bursts(REP);
        add_run(5'b00000, 10);
        check_runs("alarm");
        chk("alarm busy_end", 32'(obs_busy[REP * (A_LEN + G_LEN) - 1]), 1);
        chk("alarm busy_idle", 32'(obs_busy[REP * (A_LEN + G_LEN)]), 0);
        idle_gap();

        // Alarm stopped during the second burst.
        s = $urandom_range(A_LEN + G_LEN + 1, 2 * A_LEN + G_LEN - 1);
        alarm_hit = 1'b1;
        step();
        alarm_hit = 1'b0;
        n = REP * (A_LEN + G_LEN) + 10;
        capture(n, s, -1);
        add_run(5'b00001, A_LEN);
        add_run(5'b00000, G_LEN);
        add_run(5'b00001, s - (A_LEN + G_LEN));
        add_run(5'b00000, n - s);
        check_runs("stop");
        chk("stop busy_gap", 32'(obs_busy[s + G_LEN - 1]), 1);
        chk("stop busy_idle", 32'(obs_busy[s + G_LEN]), 0);
        idle_gap();

        // Re-hit during the last burst reloads the repeats: two extra bursts.
        s = $urandom_range(2 * (A_LEN + G_LEN) + 1, 3 * A_LEN + 2 * G_LEN - 2);
        alarm_hit = 1'b1;
        step();
        alarm_hit = 1'b0;
        n = (REP + 2) * (A_LEN + G_LEN) + 10;
        capture(n, -1, s);
        add_alarm_bursts(REP + 2);
        add_run(5'b00000, 10);
        check_runs("reload");
        idle_gap();

        // Chime preempted by alarm; chime is not replayed.
        for (int it = 0; it < 3; it++) begin
            a = (it == 0) ? 10 : $urandom_range(1, C_LEN - 2);
            hour_hit = 1'b1;
            step();
            hour_hit = 1'b0;
            n = a + 1 + G_LEN + 1 + REP * (A_LEN + G_LEN) + 10;
            capture(n, -1, a);
            add_run(5'b00010, a + 1);
            add_run(5'b00000, G_LEN + 1);
            add_alarm_bursts(REP);
            add_run(5'b00000, 10);
            check_runs($sformatf("preempt%0d", it));
            idle_gap();
        end

        // Stop and alarm in the same cycle: nothing starts.
        alarm_hit = 1'b1;
        stop_key  = 1'b1;
        step();
        alarm_hit = 1'b0;
        stop_key  = 1'b0;
        capture(20, -1, -1);
        add_run(5'b00000, 20);
        check_runs("stop_wins");
        chk("stop_wins busy", 32'(obs_busy[19]), 0);

        // Volume: random ops, then saturation and simultaneous press.
        for (int i = 0; i < 60; i++) begin
            vol_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $sformatf("vol_rand%0d", i));
        end
        for (int i = 0; i < 40; i++) vol_op(1'b1, 1'b0, "vol_up");
        chk("vol_max", 32'(volume), VMAX);
        vol_op(1'b1, 1'b1, "vol_both");
        for (int i = 0; i < 40; i++) vol_op(1'b0, 1'b1, "vol_dn");
        chk("vol_min", 32'(volume), 0);
        vol_op(1'b1, 1'b0, "vol_up_a");
        vol_op(1'b1, 1'b0, "vol_up_b");

        // Asynchronous reset mid-PLAY with a chime pending.
        alarm_hit = 1'b1;
        step();
        alarm_hit = 1'b0;
        repeat (10) step();
        hour_hit = 1'b1;
        step();
        hour_hit = 1'b0;
        repeat (8) step();
        chk("pre_rst start", 32'(start), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async start", 32'(start), 0);
        chk("async busy", 32'(busy), 0);
        chk("async volume", 32'(volume), 32);
        mv = 32;
        repeat (2) step();
        rst = 1'b0;
        capture(120, -1, -1);
        add_run(5'b00000, 120);
        check_runs("after_rst");
        any_busy = 0;
        foreach (obs_busy[i]) if (obs_busy[i] !== 1'b0) any_busy++;
        chk("after_rst busy", any_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chime_ctrl.md
# chime_ctrl

Request-side controller for the music player interface: it turns clock events (alarm hit, hourly chime, key press) into the one-hot `start` level and `volume` word that the player consumes. It owns request arbitration, play duration, alarm repetition, inter-tune gaps and the user volume setting. It sits between the clock/alarm logic and `player_itf`, which turns `start`/`volume` into `beep`.

## Interface
- MSC_N, 5: width of `start`, matching the `MSC_N` macro; must be ≥ 3.
- TICK_DIV, 50000: sysclk cycles per duration tick (1 ms at 50 MHz).
- ALARM_MS, 500: alarm tune length in ticks.
- CHIME_MS, 200: hourly chime length in ticks.
- CLICK_MS, 30: key-click length in ticks.
- GAP_MS, 100: silent gap after every tune, in ticks.
- ALARM_REP, 10: number of alarm plays per `alarm_hit`.
- VOL_STEP, 32: volume increment/decrement.
- VOL_INIT, 32: volume after reset (10'b0000_1_0000_0).
- sysclk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- alarm_hit  in  1  request alarm tune; sampled per cycle.
- hour_hit  in  1  request hourly chime.
- key_hit  in  1  request key click.
- stop_key  in  1  cancel the alarm.
- vol_up  in  1  raise the volume by VOL_STEP.
- vol_dn  in  1  lower the volume by VOL_STEP.
- start  out  MSC_N  one-hot tune select, held high for the whole tune: bit0 = alarm, bit1 = chime, bit2 = click; other bits are always 0.
- volume  out  10  volume to the player.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- Pending flags: one per source. A high input at an edge sets its flag. A repeated request while the flag is already set is absorbed.
- `alarm_hit` while the alarm is active (playing or in a repeat gap) reloads the repeat counter to ALARM_REP−1 and sets no flag.
- Arbitration priority is alarm > chime > click.
- FSM states:
  - IDLE: if any flag is set, take the highest-priority source, clear its flag, drive its `start` bit, load the timer with its duration, clear the prescaler, and go to PLAY. Alarm selection loads the repeat counter with ALARM_REP−1.
  - PLAY: the timer decrements on each tick. At 0, drive `start`=0, load GAP_MS, clear the prescaler, and go to GAP.
  - GAP: at 0, if the last tune was the alarm and the repeat counter is nonzero, decrement the counter and replay the alarm (return to PLAY). Otherwise go to IDLE.
- Preemption: if the alarm flag sets while the chime or click is in PLAY, the current tune is aborted. Next edge: `start`=0, go to GAP. The aborted request is dropped.
- `stop_key`:
  - Clears the alarm flag and the repeat counter.
  - If the alarm is in PLAY, next edge `start`=0 and go to GAP.
  - If the alarm is in GAP, the gap completes and the FSM goes to IDLE.
  - `stop_key` and `alarm_hit` in the same cycle: stop wins and the alarm is not started.
- Volume: a saturating 10-bit register.
  - `vol_up` adds VOL_STEP, clamped at 1023−(1023 mod VOL_STEP) (992 for the defaults).
  - `vol_dn` subtracts VOL_STEP, clamped at 0.
  - Both high in the same cycle: no change.
  - Volume updates in any state.
- Prescaler: counts 0..TICK_DIV−1 and emits a tick on wrap. It is cleared on every timer load.

## Timing
- Reset values: `start`=0, `volume`=VOL_INIT, `busy`=0, state IDLE, all flags, timers, prescaler and repeat counter 0.
- Request latency: input high at edge N sets the flag; `start` and `busy` are valid after edge N+1 (FSM in IDLE).
- `start` high for exactly duration×TICK_DIV cycles, then low for exactly GAP_MS×TICK_DIV cycles. Aborted tunes are shorter; the gap is always full length.
- `start` changes only on FSM transitions and never switches directly from one nonzero value to another.
- `busy` falls on the edge the GAP exits to IDLE. A flag pending at that point starts its tune one edge later.
- `rst` mid-operation: all outputs return to their reset values immediately (asynchronously) and pending requests are lost.

## Configuration
- `CHIME_KEYCLICK_EN` defined: `key_hit` is live and the click uses `start[2]`.
- Not defined: `key_hit` is ignored, there is no click flag, and `start[2]` is constant 0. All other behaviour is unchanged.

## Test plan
Bench parameters: TICK_DIV=10, ALARM_MS=5, CHIME_MS=4, CLICK_MS=2, GAP_MS=3, ALARM_REP=3, `CHIME_KEYCLICK_EN` defined.
- Reset → `start`=5'b00000, `volume`=32, `busy`=0, held through release.
- One-cycle `key_hit` at edge N → after N+1 `start`=5'b00100 for 20 cycles, then 0 for 30 cycles, then `busy`=0.
- `alarm_hit` → three 50-cycle `start`=5'b00001 bursts separated by 30-cycle gaps. Repeat with `stop_key` during the 2nd burst → `start`=0 next edge, no 3rd burst.
- `hour_hit` (playing 5'b00010), then `alarm_hit` 10 cycles later → `start`=0 next edge, 30-cycle gap, then 5'b00001. The chime is not replayed.
- `vol_up` ×40 → `volume`=992. `vol_dn` ×40 → 0. `vol_up` and `vol_dn` together → unchanged.
- `rst` pulsed mid-PLAY → `start`=0 and `busy`=0 without waiting for a clock edge. No tune resumes after release.
